// File: rtl/ped_request_ctrl_if.sv
// Pedestrian request bundle between the button front-end and its consumer.
//   btn     : raw push-buttons, bit i = crossing i+1, asynchronous, 1 = pressed
//   walk    : controller walk outputs {P4,P3,P2,P1}, synchronous to clk
//   req     : pending request per crossing
//   urgent  : request pending for too long
//   any_req : OR of req
//   btn_db  : debounced button level
// master = controller/bench side, slave = ped_request_ctrl.
interface ped_request_ctrl_if;
  logic [3:0] btn;
  logic [3:0] walk;
  logic [3:0] req;
  logic [3:0] urgent;
  logic       any_req;
  logic [3:0] btn_db;

  modport master (
    output btn,
    output walk,
    input  req,
    input  urgent,
    input  any_req,
    input  btn_db
  );

  modport slave (
    input  btn,
    input  walk,
    output req,
    output urgent,
    output any_req,
    output btn_db
  );
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian request conditioning for the 4-way traffic controller.
// Each raw button is synchronised, debounced on a slow sample tick and latched
// as a pending request until the controller raises the matching walk output.
// Requests waiting URGENT_TICKS sample ticks or longer are flagged urgent.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   ped   : slave side of ped_request_ctrl_if (btn/walk in; req/urgent/any_req/btn_db out)
module ped_request_ctrl #(
  parameter int unsigned SAMPLE_DIV   = 100000,
  parameter int unsigned DEB_SAMPLES  = 8,
  parameter int unsigned WAIT_W       = 12,
  parameter int unsigned URGENT_TICKS = 2000
) (
  input logic               clk,
  input logic               reset,
  ped_request_ctrl_if.slave ped
);

  localparam int unsigned N      = 4;
  localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned DCNT_W = $clog2(DEB_SAMPLES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_SAMPLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_URG  = WAIT_W'(URGENT_TICKS);

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_DN_PEND = 2'd1,
    ST_DOWN    = 2'd2,
    ST_UP_PEND = 2'd3
  } deb_state_e;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_c;
  logic [N-1:0]      sync1_q, sync2_q;
  deb_state_e        deb_q  [N];
  deb_state_e        deb_d  [N];
  logic [DCNT_W-1:0] dcnt_q [N];
  logic [DCNT_W-1:0] dcnt_d [N];
  logic [N-1:0]      press_evt_c;
  logic [N-1:0]      req_q, req_d;
  logic [N-1:0]      urgent_q, urgent_d;
  logic              any_req_q, any_req_d;
  logic [N-1:0]      btn_db_q, btn_db_d;
  logic [WAIT_W-1:0] wcnt_q [N];
  logic [WAIT_W-1:0] wcnt_d [N];

  // Sample-tick prescaler
  assign tick_c = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick_c ? '0 : div_q + DIV_W'(1);
  end

  // Debounce FSMs: only move on a sample tick; press_evt marks the entry into DOWN
  always_comb begin
    for (int i = 0; i < N; i++) begin
      deb_d[i]       = deb_q[i];
      dcnt_d[i]      = dcnt_q[i];
      press_evt_c[i] = 1'b0;
      if (tick_c) begin
        unique case (deb_q[i])
          ST_UP: begin
            if (sync2_q[i]) begin
              if (DEB_SAMPLES == 1) begin
                deb_d[i]       = ST_DOWN;
                dcnt_d[i]      = '0;
                press_evt_c[i] = 1'b1;
              end else begin
                deb_d[i]  = ST_DN_PEND;
                dcnt_d[i] = DCNT_W'(1);
              end
            end
          end
          ST_DN_PEND: begin
            if (!sync2_q[i]) begin
              deb_d[i]  = ST_UP;
              dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DCNT_LAST) begin
              deb_d[i]       = ST_DOWN;
              dcnt_d[i]      = '0;
              press_evt_c[i] = 1'b1;
            end else begin
              dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
            end
          end
          ST_DOWN: begin
            if (!sync2_q[i]) begin
              if (DEB_SAMPLES == 1) begin
                deb_d[i]  = ST_UP;
                dcnt_d[i] = '0;
              end else begin
                deb_d[i]  = ST_UP_PEND;
                dcnt_d[i] = DCNT_W'(1);
              end
            end
          end
          ST_UP_PEND: begin
            if (sync2_q[i]) begin
              deb_d[i]  = ST_DOWN;
              dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DCNT_LAST) begin
              deb_d[i]  = ST_UP;
              dcnt_d[i] = '0;
            end else begin
              dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
            end
          end
          default: begin
            deb_d[i]  = ST_UP;
            dcnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Request latch, saturating wait counter and urgency flag per crossing.
  // Urgency is taken from the current request/count so it drops one clk after req.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_d[i]    = ped.walk[i] ? 1'b0 : (req_q[i] | press_evt_c[i]);
      urgent_d[i] = req_q[i] & (wcnt_q[i] >= WAIT_URG);
      btn_db_d[i] = (deb_d[i] == ST_DOWN) || (deb_d[i] == ST_UP_PEND);
      wcnt_d[i]   = wcnt_q[i];
      if (!req_d[i]) begin
        wcnt_d[i] = '0;
      end else if (tick_c && req_q[i] && (wcnt_q[i] != WAIT_MAX)) begin
        wcnt_d[i] = wcnt_q[i] + WAIT_W'(1);
      end
    end
    any_req_d = |req_d;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      req_q     <= '0;
      urgent_q  <= '0;
      any_req_q <= 1'b0;
      btn_db_q  <= '0;
      for (int i = 0; i < N; i++) begin
        deb_q[i]  <= ST_UP;
        dcnt_q[i] <= '0;
        wcnt_q[i] <= '0;
      end
    end else begin
      div_q     <= div_d;
      sync1_q   <= ped.btn;
      sync2_q   <= sync1_q;
      req_q     <= req_d;
      urgent_q  <= urgent_d;
      any_req_q <= any_req_d;
      btn_db_q  <= btn_db_d;
      for (int i = 0; i < N; i++) begin
        deb_q[i]  <= deb_d[i];
        dcnt_q[i] <= dcnt_d[i];
        wcnt_q[i] <= wcnt_d[i];
      end
    end
  end

  assign ped.req     = req_q;
  assign ped.urgent  = urgent_q;
  assign ped.any_req = any_req_q;
  assign ped.btn_db  = btn_db_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a run-length reference model.
module tb_ped_request_ctrl;

  localparam int unsigned SD   = 4;
  localparam int unsigned DS   = 3;
  localparam int unsigned WW   = 4;
  localparam int unsigned UT   = 5;
  localparam int          WMAX = (1 << WW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ped_request_ctrl_if bus ();

  ped_request_ctrl #(
    .SAMPLE_DIV  (SD),
    .DEB_SAMPLES (DS),
    .WAIT_W      (WW),
    .URGENT_TICKS(UT)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .ped  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: accepted level + count of consecutive differing samples
  int         m_pc;
  logic [3:0] m_s1, m_s2, m_db, m_req, m_urg;
  logic       m_any;
  int         m_run [4];
  int         m_w   [4];

  logic       nx_tick;
  int         nx_pc;
  logic [3:0] nx_db, nx_req, nx_urg, nx_press;
  int         nx_run [4];
  int         nx_w   [4];

  always_comb begin
    nx_tick  = (m_pc == SD - 1);
    nx_pc    = nx_tick ? 0 : m_pc + 1;
    nx_db    = m_db;
    nx_req   = '0;
    nx_urg   = '0;
    nx_press = '0;
    for (int i = 0; i < 4; i++) begin
      nx_run[i] = m_run[i];
      nx_w[i]   = m_w[i];
      if (nx_tick) begin
        if (m_s2[i] != m_db[i]) begin
          if (m_run[i] + 1 >= DS) begin
            nx_db[i]    = m_s2[i];
            nx_run[i]   = 0;
            nx_press[i] = m_s2[i];
          end else begin
            nx_run[i] = m_run[i] + 1;
          end
        end else begin
          nx_run[i] = 0;
        end
      end
      nx_req[i] = bus.walk[i] ? 1'b0 : (m_req[i] | nx_press[i]);
      nx_urg[i] = m_req[i] && (m_w[i] >= UT);
      if (!nx_req[i])                 nx_w[i] = 0;
      else if (nx_tick && m_req[i])   nx_w[i] = (m_w[i] < WMAX) ? m_w[i] + 1 : WMAX;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc  <= 0;
      m_s1  <= '0;
      m_s2  <= '0;
      m_db  <= '0;
      m_req <= '0;
      m_urg <= '0;
      m_any <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_run[i] <= 0;
        m_w[i]   <= 0;
      end
    end else begin
      m_pc  <= nx_pc;
      m_s1  <= bus.btn;
      m_s2  <= m_s1;
      m_db  <= nx_db;
      m_req <= nx_req;
      m_urg <= nx_urg;
      m_any <= |nx_req;
      for (int i = 0; i < 4; i++) begin
        m_run[i] <= nx_run[i];
        m_w[i]   <= nx_w[i];
      end
    end
  end

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_req",     bus.req,              m_req);
      cmp("model_urgent",  bus.urgent,           m_urg);
      cmp("model_any_req", {3'b000, bus.any_req}, {3'b000, m_any});
      cmp("model_btn_db",  bus.btn_db,           m_db);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string nm, input logic [3:0] m, input int bound);
    int cyc;
    cyc = 0;
    while (((bus.req & m) != m) && (cyc < bound)) begin
      @(negedge clk);
      cyc++;
    end
    cmp(nm, {3'b000, ((bus.req & m) == m)}, 4'b0001);
  endtask

  task automatic check_all_zero(input string nm);
    cmp({nm, "_req"},     bus.req,                '0);
    cmp({nm, "_urgent"},  bus.urgent,             '0);
    cmp({nm, "_any_req"}, {3'b000, bus.any_req},  '0);
    cmp({nm, "_btn_db"},  bus.btn_db,             '0);
  endtask

  int wl [4];

  initial begin
    bus.btn  = '0;
    bus.walk = '0;
    @(posedge clk);
    chk_en = 1'b1;
    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Clean press on crossing 1
    bus.btn = 4'b0001;
    wait_req("clean_press_latency", 4'b0001, 15);
    cmp("clean_press_req", bus.req, 4'b0001);
    cmp("clean_press_any", {3'b000, bus.any_req}, 4'b0001);
    cmp("clean_press_db",  {3'b000, bus.btn_db[0]}, 4'b0001);
    bus.btn = '0;
    step(20);
    cmp("req_holds", bus.req, 4'b0001);

    // Bounce on crossing 3: 5-clk toggles never survive 3 samples
    for (int k = 0; k < 8; k++) begin
      bus.btn[2] = ~bus.btn[2];
      for (int c = 0; c < 5; c++) begin
        step(1);
        cmp("bounce_req",    {3'b000, bus.req[2]},    '0);
        cmp("bounce_btn_db", {3'b000, bus.btn_db[2]}, '0);
      end
    end
    step(20);
    cmp("bounce_after", {3'b000, bus.req[2]}, '0);

    // Service of crossing 2, then press while walk is high
    bus.btn[1] = 1'b1;
    wait_req("svc_press", 4'b0010, 15);
    bus.walk = 4'b0010;
    step(1);
    bus.walk = '0;
    cmp("svc_req_clear", {3'b000, bus.req[1]},    '0);
    cmp("svc_urgent",    {3'b000, bus.urgent[1]}, '0);
    step(1);
    cmp("svc_urgent2",   {3'b000, bus.urgent[1]}, '0);
    step(20);
    cmp("held_no_rereq", {3'b000, bus.req[1]}, '0);
    bus.btn[1] = 1'b0;
    step(20);
    bus.walk   = 4'b0010;
    bus.btn[1] = 1'b1;
    step(20);
    cmp("press_during_walk", {3'b000, bus.req[1]}, '0);
    bus.btn[1] = 1'b0;
    step(20);
    bus.walk = '0;
    step(2);

    // Urgency and saturation on crossing 4
    bus.btn[3] = 1'b1;
    wait_req("urg_press", 4'b1000, 15);
    step(24);
    cmp("urgent_set", {3'b000, bus.urgent[3]}, 4'b0001);
    step(60);
    cmp("urgent_saturated", {3'b000, bus.urgent[3]}, 4'b0001);
    bus.walk = 4'b1000;
    step(1);
    bus.walk = '0;
    cmp("urg_req_clear", {3'b000, bus.req[3]}, '0);
    step(1);
    cmp("urgent_clear", {3'b000, bus.urgent[3]}, '0);
    bus.btn[3] = 1'b0;
    step(20);

    // Held button through service of crossing 1
    bus.btn[0] = 1'b1;
    step(20);
    bus.walk = 4'b0001;
    step(1);
    bus.walk = '0;
    cmp("held_svc_clear", {3'b000, bus.req[0]}, '0);
    step(30);
    cmp("held_svc_norereq", {3'b000, bus.req[0]}, '0);
    bus.btn[0] = 1'b0;
    step(20);
    bus.btn[0] = 1'b1;
    wait_req("repress", 4'b0001, 15);
    bus.btn[0] = 1'b0;
    step(20);

    // Async reset mid-debounce with requests pending
    bus.walk = 4'b0001;
    step(1);
    bus.walk = '0;
    bus.btn  = 4'b1010;
    step(20);
    bus.btn = '0;
    step(20);
    cmp("pre_reset_req", bus.req, 4'b1010);
    bus.btn = 4'b0001;
    step(6);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    step(2);
    rst_n = 1'b1;
    wait_req("post_reset_press", 4'b0001, 15);
    cmp("post_reset_req", bus.req, 4'b0001);
    bus.btn = '0;
    step(20);

    // Randomized phase
    for (int i = 0; i < 4; i++) wl[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step(1);
      if (cyc == 2000) rst_n = 1'b0;
      if (cyc == 2003) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 59) == 0) bus.btn[i] = ~bus.btn[i];
        if (wl[i] > 0) wl[i]--;
        else if ($urandom_range(0, 99) == 0) wl[i] = int'($urandom_range(1, 3));
        bus.walk[i] = (wl[i] > 0);
      end
    end
    bus.btn  = '0;
    bus.walk = '0;
    step(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
